// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction-fetch front end: widths, fetch FSM states and the
// buffered fetch entry.
package instr_fetch_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDrop
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: valid/ready request channel plus an unthrottled response.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic               imem_req_valid;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_req_ready;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Circular FIFO of fetch entries with flush; head is read directly from the storage registers.
module fetch_buffer
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               entry_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic                       valid_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_pop;

    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i & valid_o;
    assign count_o = count_q;
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push_i) - CntW'(do_pop);
        end
    end

    // Storage needs no reset: it is only visible through valid_o-qualified reads.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i && !reset) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the fetch PC, keeps at most one read in flight, buffers returned
// instructions for decode and squashes in-flight reads on redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_target,
    instr_fetch_unit_if.master  imem,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [ADDR_W-1:0]   if_pc_plus4,
    input  logic                id_ready
);

    localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned OccW = CntW + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;

    fetch_entry_t      head, push_entry;
    logic [CntW-1:0]   buf_count;
    logic [OccW-1:0]   occ;
    logic              pop, push, accept, rsp;
    logic              unused_tgt;

    assign unused_tgt = ^redirect_target[1:0];
    assign rsp        = imem.imem_rsp_valid;
    assign pop        = if_valid & id_ready;

    // Occupancy counts the live in-flight read so a response can never find the buffer full.
    assign occ = OccW'(buf_count) + OccW'(state_q == StBusy) - OccW'(pop);

    assign imem.imem_req_valid = !reset && !redirect_valid && (occ < OccW'(BUF_DEPTH)) &&
                                 ((state_q == StIdle) || rsp);
    assign imem.imem_req_addr  = fetch_pc_q;
    assign accept              = imem.imem_req_valid & imem.imem_req_ready;

    assign push             = (state_q == StBusy) && rsp && !redirect_valid;
    assign push_entry.instr = imem.imem_rsp_data;
    assign push_entry.pc    = req_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_target[ADDR_W-1:2], 2'b00};
            unique case (state_q)
                StBusy, StDrop: state_d = rsp ? StIdle : StDrop;
                default:        state_d = StIdle;
            endcase
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                req_pc_d   = fetch_pc_q;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) state_d = StBusy;
                end
                StBusy, StDrop: begin
                    if (rsp) state_d = accept ? StBusy : StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_buffer #(
        .Depth (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .valid_o (if_valid),
        .count_o (buf_count)
    );

    assign if_instr    = head.instr;
    assign if_pc       = head.pc;
    assign if_pc_plus4 = if_valid ? head.pc + ADDR_W'(4) : '0;

    a_rsp_while_idle: assert property (@(posedge clk) disable iff (reset)
        !(rsp && (state_q == StIdle)));

    a_req_aligned: assert property (@(posedge clk) disable iff (reset)
        imem.imem_req_valid |-> (imem.imem_req_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle table for streaming/stall/reset plus
// hand-written redirect and wrap sequences against a latency-programmable memory model.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;
    logic        id_ready;

    always #5 clk = ~clk;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem            (imem_bus),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .id_ready        (id_ready)
    );

    typedef struct {
        bit          rst;
        bit          idr;
        bit          rv;
        logic [31:0] ra;
        bit          ifv;
        logic [31:0] pc;
    } vec_t;

    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_wait;
    int          lat;

    bit          s_rv, s_ifv;
    logic [31:0] s_ra, s_pc, s_pc4, s_instr;
    logic [31:0] deliv[$];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample mid-cycle, then advance one clock and update the one-deep memory model.
    task automatic tick();
        bit acc;
        #2;
        s_rv    = imem_bus.imem_req_valid;
        s_ra    = imem_bus.imem_req_addr;
        s_ifv   = if_valid;
        s_pc    = if_pc;
        s_pc4   = if_pc_plus4;
        s_instr = if_instr;
        acc     = s_rv && imem_bus.imem_req_ready;
        if (s_ifv && id_ready && !reset) deliv.push_back(s_pc);
        @(posedge clk);
        #1;
        if (reset) begin
            mem_pend = 1'b0;
        end else begin
            if (imem_bus.imem_rsp_valid) mem_pend = 1'b0;
            else if (mem_pend && mem_wait > 0) mem_wait--;
            if (acc) begin
                mem_pend = 1'b1;
                mem_addr = s_ra;
                mem_wait = lat - 1;
            end
        end
        imem_bus.imem_rsp_valid = mem_pend && (mem_wait == 0);
        imem_bus.imem_rsp_data  = mem_pend ? mem_word(mem_addr) : 32'h0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bit found;
        reset                   = 1'b1;
        redirect_valid          = 1'b0;
        redirect_target         = 32'h0;
        id_ready                = 1'b1;
        lat                     = 1;
        mem_pend                = 1'b0;
        mem_addr                = 32'h0;
        mem_wait                = 0;
        imem_bus.imem_req_ready = 1'b1;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = 32'h0;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst.req_valid", s_rv, 0);
        chk("rst.if_valid", s_ifv, 0);
        chk("rst.if_pc", s_pc, 0);
        chk("rst.if_pc_plus4", s_pc4, 0);
        chk("rst.if_instr", s_instr, 0);

        //                rst   idr   rv    ra            ifv   pc
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h4,        1'b0, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h8,        1'b1, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'hC,        1'b1, 32'h4});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h10,       1'b1, 32'h8});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hC});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h4,        1'b0, 32'h0});
        for (int k = 0; k < 5; k++) begin
            tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h0});
        end
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h8,        1'b1, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'hC,        1'b1, 32'h4});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h10,       1'b1, 32'h8});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0});

        for (int i = 0; i < tbl.size(); i++) begin
            reset    = tbl[i].rst;
            id_ready = tbl[i].idr;
            tick();
            chk($sformatf("v%0d.req_valid", i), s_rv, tbl[i].rv);
            if (tbl[i].rv) chk($sformatf("v%0d.req_addr", i), s_ra, tbl[i].ra);
            chk($sformatf("v%0d.if_valid", i), s_ifv, tbl[i].ifv);
            if (tbl[i].ifv) begin
                chk($sformatf("v%0d.if_pc", i), s_pc, tbl[i].pc);
                chk($sformatf("v%0d.if_pc_plus4", i), s_pc4, tbl[i].pc + 32'd4);
                chk($sformatf("v%0d.if_instr", i), s_instr, mem_word(tbl[i].pc));
            end
        end

        // Redirect while a slow read of 0x8 is in flight: its data must be dropped.
        lat = 3;
        do_reset();
        deliv.delete();
        id_ready = 1'b1;
        repeat (8) tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        tick();
        chk("A.redir_req_valid", s_rv, 0);
        redirect_valid = 1'b0;
        tick();
        chk("A.target_req_valid", s_rv, 1);
        chk("A.target_req_addr", s_ra, 32'h100);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (s_ifv) found = 1'b1;
        end
        chk("A.deliver_timeout", found, 1);
        if (found) begin
            chk("A.first_pc", s_pc, 32'h100);
            chk("A.first_instr", s_instr, mem_word(32'h100));
        end
        chk("A.deliv_count", deliv.size(), 3);
        if (deliv.size() >= 3) begin
            chk("A.deliv1", deliv[1], 32'h4);
            chk("A.deliv2", deliv[2], 32'h100);
        end

        // Redirect in the same cycle as the response for 0x4.
        lat = 1;
        do_reset();
        deliv.delete();
        id_ready = 1'b1;
        tick();
        tick();
        id_ready        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        tick();
        chk("B.redir_req_valid", s_rv, 0);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        tick();
        chk("B.next_req_valid", s_rv, 1);
        chk("B.next_req_addr", s_ra, 32'h100);
        chk("B.flushed_if_valid", s_ifv, 0);
        tick();
        chk("B.gap_if_valid", s_ifv, 0);
        tick();
        chk("B.first_if_valid", s_ifv, 1);
        chk("B.first_pc", s_pc, 32'h100);
        chk("B.deliv_count", deliv.size(), 1);
        if (deliv.size() >= 1) chk("B.deliv0", deliv[0], 32'h100);

        // Unaligned target near the top of the address space, then wrap to zero.
        do_reset();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFE;
        tick();
        chk("C.redir_req_valid", s_rv, 0);
        redirect_valid = 1'b0;
        tick();
        chk("C.req_valid0", s_rv, 1);
        chk("C.req_addr0", s_ra, 32'hFFFF_FFFC);
        tick();
        chk("C.req_addr1", s_ra, 32'h0);
        chk("C.early_if_valid", s_ifv, 0);
        tick();
        chk("C.head_valid", s_ifv, 1);
        chk("C.head_pc", s_pc, 32'hFFFF_FFFC);
        chk("C.head_pc_plus4", s_pc4, 32'h0);
        chk("C.head_instr", s_instr, mem_word(32'hFFFF_FFFC));
        chk("C.req_addr2", s_ra, 32'h4);
        tick();
        chk("C.wrap_pc", s_pc, 32'h0);
        chk("C.wrap_pc_plus4", s_pc4, 32'h4);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
